if_id_queue: RTL
================

Name: if_id_queue

Overview:
Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry first-word-fall-through instruction queue between the fetch and decode stages. The queue decouples fetch from decode stalls, supports a flush on redirect, and presents a zero bubble (pc=0, inst=0, valid=0) to ID whenever it has nothing to issue. Ctrl stall semantics are kept: one selectable bit of the stall bus freezes issue to ID.

Parameters:
PC_W, 32, width of instruction address
INST_W, 32, width of instruction word
DEPTH, 4, number of entries; power of two, >= 2
STALL_W, 6, width of ctrl stall bus
ISSUE_STALL_BIT, 2, stall_sign bit that freezes issue to ID

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_sign  in  STALL_W  stall vector from ctrl
flush  in  1  redirect/mispredict; discard all entries
if_valid  in  1  IF presents a fetched instruction
if_pc  in  PC_W  address of fetched instruction
if_inst  in  INST_W  fetched instruction
if_ready  out  1  queue accepts a push this cycle
id_valid  out  1  head entry is valid and presented to ID
id_pc  out  PC_W  head pc, or 0 when empty
id_inst  out  INST_W  head inst, or 0 when empty
count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n=0, asynchronous): rd_ptr=wr_ptr=0, count=0. Outputs: id_valid=0, id_pc=0, id_inst=0, if_ready=1. Storage contents are don't-care. Deassertion is sampled at the next clk edge.
- pop = id_valid & ~stall_sign[ISSUE_STALL_BIT]. ID consumes the head at the edge where pop=1.
- if_ready = (count < DEPTH) | pop. A push into a full queue is allowed when a pop occurs in the same cycle.
- push = if_valid & if_ready & ~flush. The entry is written at wr_ptr, and wr_ptr advances mod DEPTH.
- count next = count + push - pop. Pointers wrap naturally at DEPTH; no wrap state bit is needed beyond count.
- Outputs are driven combinationally from the head storage register and count, with no combinational path from if_* to id_*.
  - id_valid = (count != 0).
  - id_pc / id_inst = head entry when count != 0, else 0.
- Latency: an entry pushed at edge N is visible on id_* after edge N, provided it is at the head. There is no same-cycle bypass when empty.
- Stall: while stall_sign[ISSUE_STALL_BIT]=1, the head is held and id_* are stable. Pushes continue until full; then if_ready=0.
- Flush, synchronous, highest priority: at the edge with flush=1, count=0 and rd_ptr=wr_ptr=0. Any concurrent push and pop are discarded. id_* read 0 after that edge.
- Empty: the pop term is 0, so count never underflows. Full without pop: if_ready=0, and if_valid is ignored with no overwrite.
- Only stall bit ISSUE_STALL_BIT is used; all other stall bits are ignored.
- Reset asserted mid-operation: queue cleared immediately, independent of clk.

Test Plan:
1. Reset then single push: rst_n=0→1, push pc=0x1000 inst=0x00000013 -> after the edge id_valid=1, id_pc=0x1000, count=1; with no stall it pops next edge, then id_*=0 and count=0.
2. Stall fill: stall_sign=6'b000100, push pc 0x0,0x4,0x8,0xC, then a 5th push 0x10 -> count=4, if_ready=0, 0x10 not stored, id_pc held at 0x0.
3. Full push+pop: full queue, release stall, push 0x10 in the same cycle -> count stays 4. Successive issue order is 0x0,0x4,0x8,0xC,0x10, with wrap of wr_ptr verified.
4. Flush with concurrent push: count=3, flush=1 and if_valid=1 pc=0x20 -> after the edge count=0, id_valid=0, id_pc=0. 0x20 is never issued.
5. Non-issue stall bit: stall_sign=6'b001000 (bit 3 only) -> issue continues normally, with no bubble or hold.
6. Async reset mid-stream: count=2, drop rst_n between edges -> id_valid, id_pc, id_inst and count go to 0 before the next clk edge; if_ready=1.

Source files
------------

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
//
// A DEPTH-entry first-word-fall-through instruction queue between fetch (IF)
// and decode (ID). Fetch can keep pushing while decode is stalled. A redirect
// (flush) empties the queue. Whenever the queue has nothing to issue, ID sees a
// zero bubble (pc=0, inst=0, valid=0).
//
// Handshake: a push happens on the rising edge where if_valid=1, if_ready=1 and
// flush=0. ID consumes the head on the rising edge where id_valid=1 and
// stall_sign[ISSUE_STALL_BIT]=0. There is no ID-side ready input. The ctrl
// stall bit is the only back-pressure ID applies.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   stall_sign  ctrl stall vector; only bit ISSUE_STALL_BIT is used
//   flush       redirect: discard every entry at this edge
//   if_valid    IF presents an instruction
//   if_pc       address of the fetched instruction
//   if_inst     fetched instruction word
//   if_ready    queue accepts a push this cycle
//   id_valid    head entry is presented to ID
//   id_pc       head pc, or 0 when empty
//   id_inst     head instruction, or 0 when empty
//   count       current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module if_id_queue #(
    parameter int PC_W            = 32,
    parameter int INST_W          = 32,
    parameter int DEPTH           = 4,
    parameter int STALL_W         = 6,
    parameter int ISSUE_STALL_BIT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [STALL_W-1:0]       stall_sign,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [PC_W-1:0]          if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [PC_W-1:0]          id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;

    logic              w_not_empty;
    logic              w_pop;
    logic              w_ready;
    logic              w_push;

    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty & ~stall_sign[ISSUE_STALL_BIT];
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_ready     = (r_count < FULL_CNT) | w_pop;
    assign w_push      = if_valid & w_ready & ~flush;

    // Pointers are exactly AW bits wide, so they wrap mod DEPTH by themselves.
    // Occupancy alone tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Flush wins over any push or pop in the same cycle.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset. Entries are only read while count says they are
    // live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= if_pc;
            r_inst_mem[r_wr_ptr] <= if_inst;
        end
    end

    // ID is driven only from registered state. There is no path from if_* to
    // id_*.
    assign if_ready = w_ready;
    assign id_valid = w_not_empty;
    assign id_pc    = w_not_empty ? r_pc_mem[r_rd_ptr]   : '0;
    assign id_inst  = w_not_empty ? r_inst_mem[r_rd_ptr] : '0;
    assign count    = r_count;

endmodule
